// File: rtl/byte_frame_parser.sv
// Frame delineator for SYNC, LEN, payload, CHK byte streams.
// Forwards payload bytes and pulses frame_ok/frame_err per frame; all outputs registered.
module byte_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data_in,
  input  logic       i_in_valid,
  output logic [7:0] o_pay_data,
  output logic       o_pay_valid,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic       o_busy,
  output logic [7:0] o_err_cnt
);

  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLen, StPayload, StCheck} state_e;

  state_e          r_state;
  logic [7:0]      r_remaining;
  logic [7:0]      r_acc;
  logic [TW-1:0]   r_tcnt;
  logic            w_len_bad;
  logic [7:0]      w_err_cnt_inc;

  assign w_len_bad     = (i_data_in == 8'd0) || (i_data_in > MaxLenB);
  assign w_err_cnt_inc = (o_err_cnt == 8'hFF) ? o_err_cnt : o_err_cnt + 8'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_remaining <= 8'd0;
      r_acc       <= 8'd0;
      r_tcnt      <= '0;
      o_pay_data  <= 8'd0;
      o_pay_valid <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
      o_err_cnt   <= 8'd0;
    end else begin
      o_pay_valid <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      if (i_in_valid) begin
        r_tcnt <= '0;
        unique case (r_state)
          StIdle: begin
            if (i_data_in == SYNC_BYTE) begin
              r_state <= StLen;
              o_busy  <= 1'b1;
            end
          end
          StLen: begin
            if (w_len_bad) begin
              r_state     <= StIdle;
              o_busy      <= 1'b0;
              o_frame_err <= 1'b1;
              o_err_cnt   <= w_err_cnt_inc;
            end else begin
              r_remaining <= i_data_in;
              r_acc       <= i_data_in;
              r_state     <= StPayload;
            end
          end
          StPayload: begin
            // SYNC_BYTE values here are ordinary data
            o_pay_data  <= i_data_in;
            o_pay_valid <= 1'b1;
            r_acc       <= r_acc ^ i_data_in;
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) r_state <= StCheck;
          end
          StCheck: begin
            r_state <= StIdle;
            o_busy  <= 1'b0;
            if (i_data_in == r_acc) begin
              o_frame_ok <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
              o_err_cnt   <= w_err_cnt_inc;
            end
          end
          default: r_state <= StIdle;
        endcase
      end else if (r_state != StIdle) begin
        // This idle cycle would be the TIMEOUT-th in a row: abort the frame
        if (r_tcnt == TLast) begin
          r_tcnt      <= '0;
          r_state     <= StIdle;
          o_busy      <= 1'b0;
          o_frame_err <= 1'b1;
          o_err_cnt   <= w_err_cnt_inc;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
    end
  end

endmodule
